// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared sizes and state encoding for the 8-requester round-robin arbiter.
package mux8_rr_arbiter_pkg;
  localparam int NREQ  = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/mux8to1_case.sv
// 8:1 single-bit multiplexer, case-based.
module mux8to1_case (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       out
);
  always_comb begin
    out = 1'b0;
    case (sel)
      3'd0:    out = in[0];
      3'd1:    out = in[1];
      3'd2:    out = in[2];
      3'd3:    out = in[3];
      3'd4:    out = in[4];
      3'd5:    out = in[5];
      3'd6:    out = in[6];
      default: out = in[7];
    endcase
  end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter with bounded burst that owns the select of an 8:1 bit mux;
// hands off between requesters without an idle cycle.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  in,
  output logic [NREQ-1:0]  grant,
  output logic [SEL_W-1:0] sel,
  output logic             out,
  output logic             valid
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             rel_now;
  logic [SEL_W-1:0] search_ptr;
  logic [SEL_W:0]   win;

  // Returns {found, index}: first requester at or after p, wrapping 7 -> 0.
  function automatic logic [SEL_W:0] find_winner(input logic [NREQ-1:0] r,
                                                 input logic [SEL_W-1:0] p);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [SEL_W:0]    res;
    dbl = {r, r} >> p;
    rot = dbl[NREQ-1:0];
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) res = {1'b1, SEL_W'(i) + p};
    end
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    valid_d    = valid_q;
    rel_now    = (state_q == GRANT) && (!req[sel_q] || (cnt_q == CNT_LAST) || !en);
    search_ptr = rel_now ? SEL_W'(sel_q + 3'd1) : ptr_q;
    win        = find_winner(req, search_ptr);

    if (rel_now) ptr_d = search_ptr;

    // A holder that has not released keeps the grant; otherwise search runs this edge.
    if ((state_q == GRANT) && !rel_now) begin
      cnt_d = cnt_q + 4'd1;
    end else if (en && win[SEL_W]) begin
      state_d = GRANT;
      sel_d   = win[SEL_W-1:0];
      grant_d = NREQ'(1) << win[SEL_W-1:0];
      valid_d = 1'b1;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
      grant_d = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign valid = valid_q;

  mux8to1_case u_mux (
    .in  (in),
    .sel (sel_q),
    .out (out)
  );
endmodule
